alu_writeback_regfile: RTL and testbench

- Register file and status-flag register directly downstream of the 32-bit ALU slices.
- Captures the ALU result bus into a 32-entry x 32-bit register array and latches the ALU carryout/overflow plus a derived zero flag.
- Supplies two read ports back to the ALU operand inputs (a, b).
- Register 0 is hardwired to zero, which is standard for the CPU datapath.

---
 rtl/alu_writeback_regfile.sv | 84 ++++++++
 tb/tb_alu_writeback_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_regfile.sv
// Write-back register file and status flags sitting behind the 32-bit ALU.
// Two combinational read ports feed the ALU operands; register 0 reads as zero.
module alu_writeback_regfile #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [DEPTH_LOG2-1:0] write_addr,
  input  logic                  reg_write,
  input  logic                  alu_carryout,
  input  logic                  alu_overflow,
  input  logic                  flag_write,
  input  logic [DEPTH_LOG2-1:0] read_addr1,
  input  logic [DEPTH_LOG2-1:0] read_addr2,
  output logic [WIDTH-1:0]      read_data1,
  output logic [WIDTH-1:0]      read_data2,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  flag_ovf,
  output logic                  flags_valid
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             r_flag_zero;
  logic             r_flag_carry;
  logic             r_flag_ovf;
  logic             r_flags_valid;

  logic             w_wr_en;
  logic             w_byp1;
  logic             w_byp2;

  // A write is effective only outside reset and never to register 0.
  assign w_wr_en = reg_write & ~reset & (write_addr != '0);
  assign w_byp1  = (BYPASS != 0) & w_wr_en & (read_addr1 == write_addr);
  assign w_byp2  = (BYPASS != 0) & w_wr_en & (read_addr2 == write_addr);

  // Register array: synchronous clear, then single-port write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // Status flags captured independently of the register write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag_zero   <= 1'b0;
      r_flag_carry  <= 1'b0;
      r_flag_ovf    <= 1'b0;
      r_flags_valid <= 1'b0;
    end else if (flag_write) begin
      r_flag_zero   <= (write_data == '0);
      r_flag_carry  <= alu_carryout;
      r_flag_ovf    <= alu_overflow;
      r_flags_valid <= 1'b1;
    end
  end

  // Read ports: zero register, optional same-cycle forwarding, else array.
  always_comb begin
    read_data1 = r_regs[read_addr1];
    read_data2 = r_regs[read_addr2];
    if (w_byp1) read_data1 = write_data;
    if (w_byp2) read_data2 = write_data;
    if (read_addr1 == '0) read_data1 = '0;
    if (read_addr2 == '0) read_data2 = '0;
  end

  assign flag_zero   = r_flag_zero;
  assign flag_carry  = r_flag_carry;
  assign flag_ovf    = r_flag_ovf;
  assign flags_valid = r_flags_valid;

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Bench for alu_writeback_regfile: one instance with forwarding, one without,
// both checked every cycle against an array model plus literal expectations.
module tb_alu_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] write_data;
  logic [4:0]  write_addr;
  logic        reg_write;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        flag_write;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        fz_b, fc_b, fo_b, fv_b;
  logic        fz_n, fc_n, fo_n, fv_n;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [32];
  logic        m_fz, m_fc, m_fo, m_fv;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_writeback_regfile #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .write_data(write_data), .write_addr(write_addr),
    .reg_write(reg_write), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .flag_write(flag_write), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_b), .read_data2(rd2_b), .flag_zero(fz_b), .flag_carry(fc_b),
    .flag_ovf(fo_b), .flags_valid(fv_b)
  );

  alu_writeback_regfile #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .write_data(write_data), .write_addr(write_addr),
    .reg_write(reg_write), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .flag_write(flag_write), .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(rd1_n), .read_data2(rd2_n), .flag_zero(fz_n), .flag_carry(fc_n),
    .flag_ovf(fo_n), .flags_valid(fv_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected read value from the model for a given forwarding setting.
  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (byp && reg_write && !reset && write_addr != 5'd0 && write_addr == ra)
      return write_data;
    return mdl[ra];
  endfunction

  // Model state advances on each rising edge from the applied inputs.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      m_fz = 0; m_fc = 0; m_fo = 0; m_fv = 0;
      chk_en = 1'b1;
    end else begin
      if (reg_write && write_addr != 5'd0) mdl[write_addr] = write_data;
      if (flag_write) begin
        m_fz = (write_data == 32'h0);
        m_fc = alu_carryout;
        m_fo = alu_overflow;
        m_fv = 1'b1;
      end
    end
  end

  // Compare process: every cycle after the first reset edge, mid-low-phase.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("byp_rd1", rd1_b, exp_rd(1'b1, read_addr1));
      chk("byp_rd2", rd2_b, exp_rd(1'b1, read_addr2));
      chk("nobyp_rd1", rd1_n, exp_rd(1'b0, read_addr1));
      chk("nobyp_rd2", rd2_n, exp_rd(1'b0, read_addr2));
      chk("byp_flags", {28'h0, fz_b, fc_b, fo_b, fv_b}, {28'h0, m_fz, m_fc, m_fo, m_fv});
      chk("nobyp_flags", {28'h0, fz_n, fc_n, fo_n, fv_n}, {28'h0, m_fz, m_fc, m_fo, m_fv});
    end
  end

  task automatic drive(input bit rst, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit fw, input bit c, input bit o,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    reset = rst; reg_write = we; write_addr = wa; write_data = wd;
    flag_write = fw; alu_carryout = c; alu_overflow = o;
    read_addr1 = ra1; read_addr2 = ra2;
    #3;
  endtask

  task automatic idle_read(input logic [4:0] ra1, input logic [4:0] ra2);
    drive(0, 0, 5'd0, 32'h0, 0, 0, 0, ra1, ra2);
  endtask

  initial begin
    reset = 1; reg_write = 0; write_addr = 0; write_data = 0;
    flag_write = 0; alu_carryout = 0; alu_overflow = 0;
    read_addr1 = 0; read_addr2 = 0;

    drive(1, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 5'd0);

    // All registers zero and flags clear after reset.
    for (int a = 0; a < 32; a++) begin
      idle_read(a[4:0], 5'(31 - a));
      chk("rst_rd1", rd1_b, 32'h0);
      chk("rst_rd2", rd2_n, 32'h0);
    end
    chk("rst_flags", {28'h0, fz_b, fc_b, fo_b, fv_b}, 32'h0);

    // Write r5, read back on both ports next cycle.
    drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd0, 5'd0);
    idle_read(5'd5, 5'd5);
    chk("r5_rd1", rd1_b, 32'hDEADBEEF);
    chk("r5_rd2", rd2_n, 32'hDEADBEEF);

    // Write to r0 is dropped, even with forwarding active.
    drive(0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 5'd0, 5'd0);
    chk("r0_wr_byp", rd1_b, 32'h0);
    idle_read(5'd0, 5'd0);
    chk("r0_rd", rd1_b, 32'h0);
    chk("r0_rd_n", rd2_n, 32'h0);

    // Same-cycle write/read of r7.
    drive(0, 1, 5'd7, 32'h11111111, 0, 0, 0, 5'd0, 5'd0);
    drive(0, 1, 5'd7, 32'h22222222, 0, 0, 0, 5'd7, 5'd7);
    chk("r7_byp", rd1_b, 32'h22222222);
    chk("r7_byp2", rd2_b, 32'h22222222);
    chk("r7_nobyp", rd1_n, 32'h11111111);
    idle_read(5'd7, 5'd7);
    chk("r7_after_b", rd1_b, 32'h22222222);
    chk("r7_after_n", rd1_n, 32'h22222222);

    // Flag capture with zero result, then hold.
    drive(0, 0, 5'd0, 32'h0, 1, 1, 0, 5'd0, 5'd0);
    drive(0, 0, 5'd0, 32'h5, 0, 0, 1, 5'd0, 5'd0);
    chk("flags_cap", {28'h0, fz_b, fc_b, fo_b, fv_b}, 32'hD);
    idle_read(5'd0, 5'd0);
    chk("flags_hold", {28'h0, fz_n, fc_n, fo_n, fv_n}, 32'hD);

    // Flags capture on a write to r0 too.
    drive(0, 1, 5'd0, 32'h8, 1, 0, 1, 5'd0, 5'd0);
    idle_read(5'd0, 5'd0);
    chk("flags_r0", {28'h0, fz_b, fc_b, fo_b, fv_b}, 32'h3);

    // Reset wins over a simultaneous write.
    drive(0, 1, 5'd31, 32'h12345678, 0, 0, 0, 5'd0, 5'd0);
    drive(1, 1, 5'd31, 32'hAAAAAAAA, 1, 1, 1, 5'd31, 5'd31);
    chk("rst_wr_pre", rd1_b, 32'h12345678);
    idle_read(5'd31, 5'd5);
    chk("rst_wr_r31", rd1_b, 32'h0);
    chk("rst_wr_r5", rd2_n, 32'h0);
    chk("rst_wr_flags", {28'h0, fz_b, fc_b, fo_b, fv_b}, 32'h0);

    // Randomized traffic, biased toward address collisions and zero data.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] wd;
      wa  = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      wd  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      drive(($urandom_range(0, 63) == 0), 1'($urandom), wa, wd, 1'($urandom),
            1'($urandom), 1'($urandom), ra1, ra2);
    end

    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
